mem1_stage: RTL

- Second memory pipeline stage. Sits between mem0 (address/byte-enable issue) and wb.
- Owns the mem0→mem1 pipeline register and the valid/allowin handshake.
- Captures synchronous data-memory read data one cycle after mem0 issued the access, and holds it across wb stalls.
- Extracts and sign/zero-extends byte/halfword/word load results and drives the mem1→wb bus.

---
 rtl/mem1_stage_if.sv | 24 ++
 rtl/mem1_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem1_stage_if.sv
// Port bundle for mem1_stage: the mem0->mem1 bus, the wb-facing bus, handshake and hazard outputs.
// slave is the stage's own view; master is the surrounding pipeline's (or a bench's) view.
interface mem1_stage_if;
  logic [75:0] mem02mem1_bus_i;
  logic        ctl_mem0_over_i;
  logic        ctl_mem1_allowin_o;
  logic        ctl_wb_allowin_i;
  logic        ctl_flush_i;
  logic [31:0] dm_rdata_i;
  logic [69:0] mem12wb_bus_o;
  logic        ctl_mem1_over_o;
  logic [4:0]  ctl_mem1_dest_o;
  logic [31:0] ctl_mem1_pc_o;

  modport slave (
    input  mem02mem1_bus_i, ctl_mem0_over_i, ctl_wb_allowin_i, ctl_flush_i, dm_rdata_i,
    output ctl_mem1_allowin_o, mem12wb_bus_o, ctl_mem1_over_o, ctl_mem1_dest_o, ctl_mem1_pc_o
  );

  modport master (
    output mem02mem1_bus_i, ctl_mem0_over_i, ctl_wb_allowin_i, ctl_flush_i, dm_rdata_i,
    input  ctl_mem1_allowin_o, mem12wb_bus_o, ctl_mem1_over_o, ctl_mem1_dest_o, ctl_mem1_pc_o
  );
endinterface

// File: rtl/mem1_stage.sv
// Second memory stage: latches mem0's bus, captures sync read data, extracts/extends loads for wb.
// One stage of latency, 1/cycle; stalls on wb_allowin=0 while holding the first-cycle read word.
module mem1_stage (
  input  logic          clk,
  input  logic          rst_n,
  mem1_stage_if.slave   io
);

  typedef struct packed {
    logic       inst_load;
    logic       inst_store;
    logic       ld_bh_sign;
    logic [2:0] ld_st_size;
  } mem_ctl_t;

  typedef struct packed {
    mem_ctl_t    ctl;
    logic [31:0] exe_result;
    logic [4:0]  wb_wdest;
    logic        wb_we;
    logic [31:0] pc;
  } mem0_bus_t;

  typedef struct packed {
    logic [31:0] wb_result;
    logic [4:0]  wb_wdest;
    logic        wb_we;
    logic [31:0] pc;
  } wb_bus_t;

  localparam logic [2:0] SIZE_BYTE = 3'b100;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b001;

  logic        mem1_valid_q, mem1_valid_d;
  mem0_bus_t   bus_q, bus_d;
  logic        first_q, first_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_data_q, hold_data_d;

  logic        allowin;
  logic [31:0] ld_word;
  logic [1:0]  addr_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wb_result;
  wb_bus_t     wb_bus;
  logic        unused_store;

  assign allowin = !mem1_valid_q || (mem1_valid_q && io.ctl_wb_allowin_i);

  // Read data is only on dm_rdata_i in the first occupied cycle; after that it must come from hold.
  always_comb begin
    mem1_valid_d = mem1_valid_q;
    bus_d        = bus_q;
    first_d      = first_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    if (io.ctl_flush_i) begin
      mem1_valid_d = 1'b0;
      hold_vld_d   = 1'b0;
      first_d      = 1'b0;
    end else if (allowin) begin
      mem1_valid_d = io.ctl_mem0_over_i;
      if (io.ctl_mem0_over_i) begin
        bus_d      = mem0_bus_t'(io.mem02mem1_bus_i);
        first_d    = 1'b1;
        hold_vld_d = 1'b0;
      end
    end else begin
      first_d = 1'b0;
      if (first_q && !hold_vld_q) begin
        hold_data_d = io.dm_rdata_i;
        hold_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem1_valid_q <= 1'b0;
      bus_q        <= '0;
      first_q      <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      mem1_valid_q <= mem1_valid_d;
      bus_q        <= bus_d;
      first_q      <= first_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign ld_word = hold_vld_q ? hold_data_q : io.dm_rdata_i;
  assign addr_lo = bus_q.exe_result[1:0];

  always_comb begin
    byte_sel = ld_word[7:0];
    case (addr_lo)
      2'd0: byte_sel = ld_word[7:0];
      2'd1: byte_sel = ld_word[15:8];
      2'd2: byte_sel = ld_word[23:16];
      2'd3: byte_sel = ld_word[31:24];
      default: byte_sel = ld_word[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    wb_result = bus_q.exe_result;
    if (bus_q.ctl.inst_load) begin
      case (bus_q.ctl.ld_st_size)
        SIZE_BYTE: wb_result = {{24{bus_q.ctl.ld_bh_sign & byte_sel[7]}}, byte_sel};
        SIZE_HALF: wb_result = {{16{bus_q.ctl.ld_bh_sign & half_sel[15]}}, half_sel};
        SIZE_WORD: wb_result = ld_word;
        default:   wb_result = 32'h0;
      endcase
    end
  end

  always_comb begin
    wb_bus.wb_result = wb_result;
    wb_bus.wb_wdest  = bus_q.wb_wdest;
    wb_bus.wb_we     = bus_q.wb_we & mem1_valid_q;
    wb_bus.pc        = bus_q.pc;
  end

  assign io.mem12wb_bus_o      = wb_bus;
  assign io.ctl_mem1_over_o    = mem1_valid_q;
  assign io.ctl_mem1_allowin_o = allowin;
  assign io.ctl_mem1_dest_o    = bus_q.wb_wdest & {5{mem1_valid_q}};
  assign io.ctl_mem1_pc_o      = bus_q.pc;

  // Store flag has no effect here; it only travels with the bus.
  assign unused_store = bus_q.ctl.inst_store;

endmodule
